// File: rtl/seg7_scan_controller_if.sv
// Host-side bundle for seg7_scan_controller: scan control, shadow-write port and display outputs.
// master = host driving digits/brightness, slave = the scan controller.
interface seg7_scan_controller_if;
    logic       en;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [4:0] wr_data;
    logic [3:0] brightness;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] digit_sel;
    logic       frame_done;

    modport master (
        output en, wr_en, wr_addr, wr_data, brightness,
        input  seg, dp, digit_sel, frame_done
    );

    modport slave (
        input  en, wr_en, wr_addr, wr_data, brightness,
        output seg, dp, digit_sel, frame_done
    );
endinterface

// File: rtl/seg7_scan_controller.sv
// Four-digit multiplexed 7-segment scanner with double-buffered digits, blanking gaps and 16-step PWM.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_controller #(
    parameter int DWELL_CYCLES = 256,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    seg7_scan_controller_if.slave  bus
);
    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [1:0]      d_r, d_s;
    logic            commit_s;
    logic [4:0]      shadow_r [4];
    logic [4:0]      active_r [4];
    logic [4:0]      digit_s;
    logic [3:0]      lead_zero_s;
    logic            lit_s;
    logic [6:0]      seg_s, seg_r;
    logic            dp_s, dp_r;
    logic [3:0]      sel_s, sel_r;
    logic            done_r;

    function automatic logic [6:0] hex_decode(input logic [3:0] hex);
        logic [6:0] segs;
        case (hex)
            4'h0:    segs = 7'h3F;
            4'h1:    segs = 7'h06;
            4'h2:    segs = 7'h5B;
            4'h3:    segs = 7'h4F;
            4'h4:    segs = 7'h66;
            4'h5:    segs = 7'h6D;
            4'h6:    segs = 7'h7D;
            4'h7:    segs = 7'h07;
            4'h8:    segs = 7'h7F;
            4'h9:    segs = 7'h6F;
            4'hA:    segs = 7'h77;
            4'hB:    segs = 7'h7C;
            4'hC:    segs = 7'h39;
            4'hD:    segs = 7'h5E;
            4'hE:    segs = 7'h79;
            4'hF:    segs = 7'h71;
            default: segs = 7'h00;
        endcase
        return segs;
    endfunction

    // Scan FSM next-state: BLANK gap then ON dwell per digit; commit at end of digit 3.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        d_s      = d_r;
        commit_s = 1'b0;
        if (bus.en) begin
            case (state_r)
                ST_BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_s = ST_ON;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_ON: begin
                    if (cnt_r == DWELL_LAST) begin
                        state_s  = ST_BLANK;
                        cnt_s    = CNT_ZERO;
                        d_s      = d_r + 2'd1;
                        commit_s = (d_r == 2'd3);
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_BLANK;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
            cnt_s   = cnt_r;
            d_s     = d_r;
        end
    end

    // Scan FSM state, dwell/blank counter and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_BLANK;
            cnt_r   <= CNT_ZERO;
            d_r     <= 2'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            d_r     <= d_s;
        end
    end

    // Shadow bank takes host writes; active bank copies shadow only at frame commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                shadow_r[k] <= 5'h00;
                active_r[k] <= 5'h00;
            end
        end else begin
            if (bus.wr_en) begin
                shadow_r[bus.wr_addr] <= bus.wr_data;
            end
            if (commit_s) begin
                for (int k = 0; k < 4; k++) begin
                    active_r[k] <= shadow_r[k];
                end
            end
        end
    end

`ifdef SEG7_LZB_EN
    // A digit is a leading zero when it and every more significant digit are zero; digit 0 never is.
    always_comb begin
        lead_zero_s    = 4'b0000;
        lead_zero_s[3] = (active_r[3][3:0] == 4'h0);
        lead_zero_s[2] = lead_zero_s[3] && (active_r[2][3:0] == 4'h0);
        lead_zero_s[1] = lead_zero_s[2] && (active_r[1][3:0] == 4'h0);
    end
`else
    assign lead_zero_s = 4'b0000;
`endif

    assign digit_s = active_r[d_r];
    assign lit_s   = (bus.brightness == 4'd15) || (cnt_r[3:0] < bus.brightness);

    // Output decode from the current scan position; digit_sel ignores PWM, segments honour it.
    always_comb begin
        seg_s = 7'h00;
        dp_s  = 1'b0;
        sel_s = 4'b0000;
        if (bus.en && (state_r == ST_ON)) begin
            sel_s = 4'b0001 << d_r;
            if (lit_s) begin
                seg_s = lead_zero_s[d_r] ? 7'h00 : hex_decode(digit_s[3:0]);
                dp_s  = digit_s[4];
            end else begin
                seg_s = 7'h00;
                dp_s  = 1'b0;
            end
        end else begin
            sel_s = 4'b0000;
        end
    end

    // Registered display outputs and frame-commit pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r  <= 7'h00;
            dp_r   <= 1'b0;
            sel_r  <= 4'b0000;
            done_r <= 1'b0;
        end else begin
            seg_r  <= seg_s;
            dp_r   <= dp_s;
            sel_r  <= sel_s;
            done_r <= commit_s;
        end
    end

    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.digit_sel  = sel_r;
    assign bus.frame_done = done_r;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller: a frame-position reference model queues the expected
// outputs for every clock and a monitor compares them one cycle later; directed phases then random traffic.
module tb_seg7_scan_controller;
    localparam int DWELL = 16;
    localparam int BLANK = 2;
    localparam int SLOT  = DWELL + BLANK;
    localparam int FRAME = 4 * SLOT;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    seg7_scan_controller_if bus ();

    seg7_scan_controller #(
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t       exp_q [$];
    int         checks = 0;
    int         fails  = 0;
    int         scan_t = 0;
    logic [4:0] m_shadow [4] = '{5'h00, 5'h00, 5'h00, 5'h00};
    logic [4:0] m_active [4] = '{5'h00, 5'h00, 5'h00, 5'h00};
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    function automatic logic zeros_from(input int slot);
        for (int j = slot; j < 4; j++) begin
            if (m_active[j][3:0] != 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference model: scan position is just the count of enabled cycles modulo the frame length.
    exp_t mdl_e;
    int   mdl_p, mdl_slot, mdl_off, mdl_c;
    logic mdl_blank;
    always @(posedge clk) begin
        mdl_e = '0;
        if (rst) begin
            scan_t = 0;
            for (int k = 0; k < 4; k++) begin
                m_shadow[k] = 5'h00;
                m_active[k] = 5'h00;
            end
        end else begin
            mdl_p    = scan_t % FRAME;
            mdl_slot = mdl_p / SLOT;
            mdl_off  = mdl_p % SLOT;
            if (bus.en) begin
                if (mdl_off >= BLANK) begin
                    mdl_c     = mdl_off - BLANK;
                    mdl_e.sel = 4'(1 << mdl_slot);
`ifdef SEG7_LZB_EN
                    mdl_blank = (mdl_slot != 0) && zeros_from(mdl_slot);
`else
                    mdl_blank = 1'b0;
`endif
                    if (bus.brightness == 4'd15 || (mdl_c % 16) < int'(bus.brightness)) begin
                        mdl_e.dp  = m_active[mdl_slot][4];
                        mdl_e.seg = mdl_blank ? 7'h00 : hex_tab[m_active[mdl_slot][3:0]];
                    end
                end
                if (mdl_p == FRAME - 1) begin
                    mdl_e.done = 1'b1;
                    for (int k = 0; k < 4; k++) m_active[k] = m_shadow[k];
                end
                scan_t = scan_t + 1;
            end
            if (bus.wr_en) m_shadow[bus.wr_addr] = bus.wr_data;
        end
        exp_q.push_back(mdl_e);
    end

    // Monitor: every clock the DUT presents a new output word; compare it against the queue head.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd0, 32'd1);
        end else begin
            mon_e = exp_q.pop_front();
            check("seg",        32'(bus.seg),        32'(mon_e.seg));
            check("dp",         32'(bus.dp),         32'(mon_e.dp));
            check("digit_sel",  32'(bus.digit_sel),  32'(mon_e.sel));
            check("frame_done", 32'(bus.frame_done), 32'(mon_e.done));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.wr_en = 1'b0;
        end
    endtask

    task automatic write(input logic [1:0] a, input logic [4:0] dt);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = dt;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    // Returns at a negedge where the next posedge sees frame position 'target'.
    task automatic wait_pos(input int target);
        for (int i = 0; i < 2 * FRAME + 2; i++) begin
            if (scan_t % FRAME == target) return;
            @(negedge clk);
            bus.wr_en = 1'b0;
        end
        check("wait_pos_timeout", 32'(scan_t % FRAME), 32'(target));
    endtask

    initial begin
        rst            = 1'b1;
        bus.en         = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = 2'd0;
        bus.wr_data    = 5'h00;
        bus.brightness = 4'd15;
        @(negedge clk);
        rst = 1'b0;
        idle(2 * FRAME);

        // Double buffering: mid-frame write only shows after the commit.
        wait_pos(30);
        write(2'd0, 5'h13);
        idle(2 * FRAME);

        // PWM at brightness 4 then 0 with digit 0 holding 8.
        wait_pos(10);
        write(2'd0, 5'h08);
        wait_pos(0);
        bus.brightness = 4'd4;
        idle(2 * FRAME);
        bus.brightness = 4'd0;
        idle(FRAME);
        bus.brightness = 4'd15;

        // Write landing on the commit edge belongs to the next frame.
        wait_pos(FRAME - 1);
        write(2'd1, 5'h0A);
        idle(2 * FRAME);

        // Scan freeze during ON of digit 2.
        wait_pos(2 * SLOT + BLANK + 5);
        bus.en = 1'b0;
        idle(10);
        bus.en = 1'b1;
        idle(FRAME);

        // Reset during ON of digit 3 clears everything, including shadow.
        wait_pos(3 * SLOT + BLANK + 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(FRAME + 5);

        // Leading-zero pattern 0042, then all zeros.
        write(2'd3, 5'h00);
        write(2'd2, 5'h00);
        write(2'd1, 5'h04);
        write(2'd0, 5'h02);
        idle(2 * FRAME);
        write(2'd1, 5'h00);
        write(2'd0, 5'h00);
        idle(2 * FRAME);

        // Random traffic: writes, brightness, enable gaps and occasional reset.
        repeat (800) begin
            @(negedge clk);
            bus.wr_en   = ($urandom % 3) == 0;
            bus.wr_addr = 2'($urandom % 4);
            bus.wr_data = 5'($urandom % 32);
            if (($urandom % 12) == 0) bus.brightness = 4'($urandom % 16);
            bus.en = ($urandom % 8) != 0;
            rst    = ($urandom % 300) == 0;
        end
        @(negedge clk);
        rst       = 1'b0;
        bus.en    = 1'b1;
        bus.wr_en = 1'b0;
        idle(FRAME);
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
